// File: rtl/sample_packer.sv
// sample_packer: packs 2-bit I/Q sample pairs from up to three channels into
// 16-bit words, MSB-first, for the packet streamer. Each append edge adds one
// group (4, 8 or 12 bits). A word is emitted with a one-cycle strobe as soon
// as 16 bits are available. Leftover bits carry into the next word.
module sample_packer #(
    parameter int COUNT_W = 16
) (
    input  logic               source_clk,
    input  logic               source_reset,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [1:0]         ch1_si,
    input  logic [1:0]         ch1_sq,
    input  logic [1:0]         ch2_si,
    input  logic [1:0]         ch2_sq,
    input  logic [1:0]         ch3_si,
    input  logic [1:0]         ch3_sq,
    output logic [15:0]        source_data,
    output logic               source_en,
    output logic [COUNT_W-1:0] word_count,
    output logic               mode_err
);

    // state  | meaning
    // S_IDLE | not streaming; waits for enable with a legal mode
    // S_RUN  | appending one group per edge using the latched mode
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_RSVD = 2'd3;

    state_t             r_state;
    logic [1:0]         r_active_mode;
    // Valid bits sit in the low r_fill positions; the oldest bit is the
    // highest valid one. The worst case is 15 leftover bits plus a 12-bit group.
    logic [26:0]        r_acc;
    logic [4:0]         r_fill;
    logic [15:0]        r_source_data;
    logic               r_source_en;
    logic [COUNT_W-1:0] r_word_count;
    logic               r_mode_err;

    logic [4:0]  w_group_w;
    logic [11:0] w_group;
    logic [26:0] w_merged;
    logic [4:0]  w_total;
    logic        w_word_done;
    logic [4:0]  w_rem;
    logic [15:0] w_word;
    logic [26:0] w_rem_mask;
    logic [26:0] w_rem_bits;

    // Build the group for the latched mode and merge it behind the held bits.
    always_comb begin
        w_group_w = 5'd4;
        w_group   = {8'd0, ch1_si, ch1_sq};
        case (r_active_mode)
            2'd1: begin
                w_group_w = 5'd8;
                w_group   = {4'd0, ch1_si, ch1_sq, ch3_si, ch3_sq};
            end
            2'd2: begin
                w_group_w = 5'd12;
                w_group   = {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq};
            end
            default: begin
                w_group_w = 5'd4;
                w_group   = {8'd0, ch1_si, ch1_sq};
            end
        endcase

        w_merged    = (r_acc << w_group_w) | {15'd0, w_group};
        w_total     = r_fill + w_group_w;
        w_word_done = (w_total >= 5'd16);
        // Only meaningful when a word completes; the top 16 valid bits leave
        // and the w_rem youngest bits stay behind.
        w_rem       = w_total - 5'd16;
        w_word      = 16'(w_merged >> w_rem);
        w_rem_mask  = (27'd1 << w_rem) - 27'd1;
        w_rem_bits  = w_merged & w_rem_mask;
    end

    // Control FSM, accumulator update and registered outputs.
    always_ff @(posedge source_clk) begin
        if (source_reset) begin
            r_state       <= S_IDLE;
            r_active_mode <= 2'd0;
            r_acc         <= '0;
            r_fill        <= 5'd0;
            r_source_data <= 16'd0;
            r_source_en   <= 1'b0;
            r_word_count  <= '0;
            r_mode_err    <= 1'b0;
        end else begin
            r_source_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        if (mode == MODE_RSVD) begin
                            r_mode_err <= 1'b1;
                        end else begin
                            // Entry edge only latches the mode; no sample taken.
                            r_state       <= S_RUN;
                            r_active_mode <= mode;
                            r_acc         <= '0;
                            r_fill        <= 5'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        // Partial word is dropped; nothing is appended here.
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                        r_fill  <= 5'd0;
                    end else if (w_word_done) begin
                        r_source_data <= w_word;
                        r_source_en   <= 1'b1;
                        r_word_count  <= r_word_count + 1'b1;
                        r_acc         <= w_rem_bits;
                        r_fill        <= w_rem;
                    end else begin
                        r_acc  <= w_merged;
                        r_fill <= w_total;
                    end
                end
            endcase
        end
    end

    assign source_data = r_source_data;
    assign source_en   = r_source_en;
    assign word_count  = r_word_count;
    assign mode_err    = r_mode_err;

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: directed scenarios plus randomized streams, all
// checked against a bit-queue reference model.
module tb_sample_packer;

    logic        source_clk = 1'b0;
    logic        source_reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  ch1_si = 2'd0, ch1_sq = 2'd0;
    logic [1:0]  ch2_si = 2'd0, ch2_sq = 2'd0;
    logic [1:0]  ch3_si = 2'd0, ch3_sq = 2'd0;
    logic [15:0] source_data, source_data4;
    logic        source_en, source_en4;
    logic [15:0] word_count;
    logic [3:0]  word_count4;
    logic        mode_err, mode_err4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_run;
    logic [1:0]  m_mode;
    bit          q[$];
    logic [15:0] m_data;
    logic        m_en;
    int          m_words;
    logic        m_err;

    sample_packer dut (
        .source_clk(source_clk), .source_reset(source_reset), .enable(enable), .mode(mode),
        .ch1_si(ch1_si), .ch1_sq(ch1_sq), .ch2_si(ch2_si), .ch2_sq(ch2_sq),
        .ch3_si(ch3_si), .ch3_sq(ch3_sq),
        .source_data(source_data), .source_en(source_en),
        .word_count(word_count), .mode_err(mode_err)
    );

    sample_packer #(.COUNT_W(4)) dut4 (
        .source_clk(source_clk), .source_reset(source_reset), .enable(enable), .mode(mode),
        .ch1_si(ch1_si), .ch1_sq(ch1_sq), .ch2_si(ch2_si), .ch2_sq(ch2_sq),
        .ch3_si(ch3_si), .ch3_sq(ch3_sq),
        .source_data(source_data4), .source_en(source_en4),
        .word_count(word_count4), .mode_err(mode_err4)
    );

    always #5 source_clk = ~source_clk;

    task automatic push_nib(input logic [1:0] si, input logic [1:0] sq);
        logic [3:0] nib;
        nib = {si, sq};
        for (int b = 3; b >= 0; b--) q.push_back(nib[b]);
    endtask

    // Advance one edge and update the model from the inputs applied on it.
    task automatic tick();
        @(posedge source_clk);
        #1;
        if (source_reset) begin
            m_run = 0; m_mode = 2'd0; q.delete();
            m_data = 16'd0; m_en = 1'b0; m_words = 0; m_err = 1'b0;
        end else begin
            m_en = 1'b0;
            if (!m_run) begin
                if (enable && mode == 2'd3) m_err = 1'b1;
                else if (enable) begin
                    m_run = 1; m_mode = mode; q.delete();
                end
            end else if (!enable) begin
                m_run = 0; q.delete();
            end else begin
                push_nib(ch1_si, ch1_sq);
                if (m_mode == 2'd2) push_nib(ch2_si, ch2_sq);
                if (m_mode != 2'd0) push_nib(ch3_si, ch3_sq);
                if (q.size() >= 16) begin
                    for (int k = 0; k < 16; k++) m_data = {m_data[14:0], q.pop_front()};
                    m_en = 1'b1;
                    m_words++;
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3);
        {ch1_si, ch1_sq} = n1;
        {ch2_si, ch2_sq} = n2;
        {ch3_si, ch3_sq} = n3;
    endtask

    task automatic drive_rand();
        drive(4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        source_reset = 1'b1; enable = 1'b0;
        tick();
        source_reset = 1'b0;
    endtask

    task automatic test_reset();
        source_reset = 1'b1; enable = 1'b1; mode = 2'd3;
        drive(4'hF, 4'hF, 4'hF);
        tick(); tick();
        n_cmp++;
        if ({source_data, source_en, word_count, mode_err} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h en=%b cnt=%0d err=%b, want all 0", source_data, source_en, word_count, mode_err);
        end
        n_cmp++;
        if ({source_data4, source_en4, word_count4, mode_err4} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs_w4: got data=%h en=%b cnt=%0d err=%b, want all 0", source_data4, source_en4, word_count4, mode_err4);
        end
        source_reset = 1'b0; enable = 1'b0; mode = 2'd0;
    endtask

    task automatic test_mode0();
        logic [3:0] nibs [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        do_reset();
        enable = 1'b1; mode = 2'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(nibs[i], 4'h0, 4'h0);
            tick();
            n_cmp++;
            if (source_en !== (i == 3)) begin
                n_bad++;
                $display("FAIL mode0_strobe append=%0d: got en=%b, want %b", i, source_en, (i == 3));
            end
        end
        n_cmp++;
        if (source_data !== 16'h1234 || word_count !== 16'd1) begin
            n_bad++;
            $display("FAIL mode0_word: got data=%h cnt=%0d, want data=1234 cnt=1", source_data, word_count);
        end
        for (int c = 0; c < 40; c++) begin
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== m_en || source_data !== m_data || word_count !== 16'(m_words)) begin
                n_bad++;
                $display("FAIL mode0_rand cyc=%0d: got en=%b data=%h cnt=%0d, want en=%b data=%h cnt=%0d", c, source_en, source_data, word_count, m_en, m_data, 16'(m_words));
            end
        end
    endtask

    task automatic test_mode1();
        logic [7:0]  grp  [4] = '{8'hA5, 8'h0F, 8'h3C, 8'hF0};
        logic [15:0] want [4] = '{16'h0, 16'hA50F, 16'h0, 16'h3CF0};
        do_reset();
        enable = 1'b1; mode = 2'd1;
        tick();
        mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            drive(grp[i][7:4], 4'h0, grp[i][3:0]);
            tick();
            n_cmp++;
            if (source_en !== (i % 2 == 1) || (i % 2 == 1 && source_data !== want[i])) begin
                n_bad++;
                $display("FAIL mode1_word append=%0d: got en=%b data=%h, want en=%b data=%h", i, source_en, source_data, (i % 2 == 1), want[i]);
            end
        end
        for (int c = 0; c < 40; c++) begin
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== m_en || source_data !== m_data || word_count !== 16'(m_words)) begin
                n_bad++;
                $display("FAIL mode1_rand cyc=%0d: got en=%b data=%h cnt=%0d, want en=%b data=%h cnt=%0d", c, source_en, source_data, word_count, m_en, m_data, 16'(m_words));
            end
        end
    endtask

    task automatic test_mode2();
        logic [11:0] grp  [4] = '{12'hABC, 12'hDEF, 12'h123, 12'h456};
        logic [15:0] want [4] = '{16'h0, 16'hABCD, 16'hEF12, 16'h3456};
        do_reset();
        enable = 1'b1; mode = 2'd2;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(grp[i][11:8], grp[i][7:4], grp[i][3:0]);
            tick();
            n_cmp++;
            if (source_en !== (i != 0) || (i != 0 && source_data !== want[i])) begin
                n_bad++;
                $display("FAIL mode2_word append=%0d: got en=%b data=%h, want en=%b data=%h", i, source_en, source_data, (i != 0), want[i]);
            end
        end
        n_cmp++;
        if (word_count !== 16'd3) begin
            n_bad++;
            $display("FAIL mode2_count: got %0d, want 3", word_count);
        end
        for (int c = 0; c < 40; c++) begin
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== m_en || source_data !== m_data || word_count !== 16'(m_words)) begin
                n_bad++;
                $display("FAIL mode2_rand cyc=%0d: got en=%b data=%h cnt=%0d, want en=%b data=%h cnt=%0d", c, source_en, source_data, word_count, m_en, m_data, 16'(m_words));
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        enable = 1'b1; mode = 2'd0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(4'(i), 4'h0, 4'h0);
            tick();
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 5; i <= 8; i++) begin
            drive(4'(i), 4'h0, 4'h0);
            tick();
            n_cmp++;
            if (source_en !== (i == 8)) begin
                n_bad++;
                $display("FAIL abort_strobe nib=%0d: got en=%b, want %b", i, source_en, (i == 8));
            end
        end
        n_cmp++;
        if (source_data !== 16'h5678 || word_count !== 16'd1) begin
            n_bad++;
            $display("FAIL abort_word: got data=%h cnt=%0d, want data=5678 cnt=1", source_data, word_count);
        end
    endtask

    task automatic test_mode_change();
        int pulses;
        do_reset();
        enable = 1'b1; mode = 2'd0;
        tick();
        mode = 2'd2;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            drive_rand();
            tick();
            if (source_en === 1'b1) pulses++;
            n_cmp++;
            if (source_en !== (c % 4 == 3)) begin
                n_bad++;
                $display("FAIL modechg_cadence append=%0d: got en=%b, want %b", c, source_en, (c % 4 == 3));
            end
        end
        n_cmp++;
        if (pulses != 2 || source_data !== m_data) begin
            n_bad++;
            $display("FAIL modechg_words: got pulses=%0d data=%h, want pulses=2 data=%h", pulses, source_data, m_data);
        end
        // mode=3 while running is ignored as well
        mode = 2'd3;
        tick();
        n_cmp++;
        if (mode_err !== 1'b0) begin
            n_bad++;
            $display("FAIL modechg_no_err: got err=%b, want 0", mode_err);
        end
    endtask

    task automatic test_reserved();
        do_reset();
        enable = 1'b1; mode = 2'd3;
        for (int c = 0; c < 6; c++) begin
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== 1'b0 || mode_err !== 1'b1) begin
                n_bad++;
                $display("FAIL reserved_idle cyc=%0d: got en=%b err=%b, want en=0 err=1", c, source_en, mode_err);
            end
        end
        mode = 2'd0;
        tick();
        for (int c = 0; c < 8; c++) begin
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== m_en || source_data !== m_data || mode_err !== 1'b1) begin
                n_bad++;
                $display("FAIL reserved_sticky cyc=%0d: got en=%b data=%h err=%b, want en=%b data=%h err=1", c, source_en, source_data, mode_err, m_en, m_data);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        enable = 1'b1; mode = 2'd1;
        tick();
        for (int c = 0; c < 34; c++) begin
            drive_rand();
            tick();
        end
        n_cmp++;
        if (word_count4 !== 4'd1 || word_count !== 16'd17) begin
            n_bad++;
            $display("FAIL wrap_count: got cnt4=%0d cnt16=%0d, want cnt4=1 cnt16=17", word_count4, word_count);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        enable = 1'b1; mode = 2'd0;
        tick();
        for (int c = 0; c < 6; c++) begin
            drive_rand();
            tick();
        end
        source_reset = 1'b1;
        tick();
        n_cmp++;
        if ({source_data, source_en, word_count, mode_err} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_mid_word: got data=%h en=%b cnt=%0d err=%b, want all 0", source_data, source_en, word_count, mode_err);
        end
        source_reset = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== (c == 3) || source_data !== m_data) begin
                n_bad++;
                $display("FAIL reset_restart append=%0d: got en=%b data=%h, want en=%b data=%h", c, source_en, source_data, (c == 3), m_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            source_reset = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
            drive_rand();
            tick();
            n_cmp++;
            if (source_en !== m_en || source_data !== m_data || word_count !== 16'(m_words) ||
                word_count4 !== 4'(m_words) || mode_err !== m_err || source_data4 !== m_data) begin
                n_bad++;
                $display("FAIL random_stream cyc=%0d: got en=%b data=%h cnt=%0d cnt4=%0d err=%b, want en=%b data=%h cnt=%0d err=%b", c, source_en, source_data, word_count, word_count4, mode_err, m_en, m_data, 16'(m_words), m_err);
            end
        end
        source_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_mode2();
        test_abort();
        test_mode_change();
        test_reserved();
        test_wrap();
        test_reset_mid_word();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
